execute_unit: RTL and testbench
===============================

Name: execute_unit

Overview:
- Execute/write-back stage directly downstream of the register file in the 8-bit processor.
- Consumes the decoded instruction fields and the two register-read data bytes, and computes the ALU result.
- Holds the zero and carry flags, drives the register-file write port, and issues jump requests back to the instruction unit.
- MUL runs as a multi-cycle sequential operation; HALT stops further instruction acceptance.

Parameters:
- DATA_W, 8: operand/result width; only 8 is verified.
- REG_AW, 3: register address width (8 registers).
- PC_W, 5: program counter width (32 instructions).
- ADDR_W, 4: jump-address field width.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  decoded instruction present this cycle
- in_ready  out  1  stage can accept an instruction
- opcode  in  4  operation code
- addr  in  ADDR_W  jump target field
- dest  in  REG_AW  destination register
- operand_a  in  DATA_W  register A data
- operand_b  in  DATA_W  register B data
- wb_en  out  1  register write strobe, one cycle per result
- wb_addr  out  REG_AW  register write address
- wb_data  out  DATA_W  register write data
- zero_flag  out  1  registered zero flag
- carry_flag  out  1  registered carry/overflow flag
- jump_en  out  1  one-cycle jump request to instruction unit
- jump_target  out  PC_W  zero-extended addr
- busy  out  1  MUL in progress
- halted  out  1  HALT executed

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, state IDLE, multiplier cleared.
  - A reset during MUL aborts it; no write-back occurs.
  - After release, in_ready=1 from the first cycle.
- Accept: an instruction is accepted on a rising edge with in_valid=1 and in_ready=1. in_ready = (state==IDLE).
- Opcodes:
  - 0 NOP; 1 ADD; 2 SUB (A-B); 3 AND; 4 OR; 5 XOR; 6 NOT A
  - 7 SHL A (carry=A[7]); 8 SHR A (carry=A[0])
  - 9 MOV A; A INC A; B CMP (A-B, flags only)
  - C MUL; D JMP; E JZ; F HALT
- Single-cycle ops: result registered on the accept edge.
  - wb_en=1 for exactly the following cycle, with wb_addr=dest and wb_data=result.
  - Latency is 1 cycle.
  - wb_en stays 0 for NOP, CMP, JMP, JZ and HALT.
- Arithmetic:
  - All ops are computed in DATA_W+1 bits.
  - ADD/INC: carry = bit 8.
  - SUB/CMP: carry = borrow (A<B).
  - AND/OR/XOR/NOT/MOV: carry cleared.
  - Results wrap modulo 256.
- Flags:
  - Updated by every op that writes back, and by CMP; zero = (result==0).
  - NOP, JMP, JZ and HALT leave the flags unchanged.
- JMP: jump_en=1 for one cycle after accept, jump_target={0,addr}.
- JZ:
  - Tests zero_flag as registered before the accept edge.
  - If it is 1, behaves like JMP; otherwise jump_en stays 0.
- MUL (FSM IDLE -> MUL -> IDLE):
  - Shift-add over DATA_W cycles; in_ready=0 and busy=1 during MUL.
  - Accept at edge N gives wb_en=1 in the cycle after edge N+8 with the low 8 product bits.
  - carry = (high product byte != 0); zero taken from the low byte.
  - in_ready returns to 1 in the same cycle as wb_en.
- HALT (FSM IDLE -> HALTED):
  - halted=1 and in_ready=0 until reset.
  - in_valid is ignored while halted.
- in_valid asserted while in_ready=0 is ignored, not queued; upstream holds the instruction.
- Back-to-back single-cycle ops are accepted every cycle.
- Operand forwarding is not provided in this stage.

Decomposition:
- Package proc_pkg:
  - opcode_t enum (NOP..HALT, values above)
  - exec_state_t enum {IDLE, MUL, HALTED}
  - DATA_W / REG_AW / PC_W constants
- Sub-module seq_multiplier:
  - start, a, b in; done, product[2*DATA_W-1:0] out.
  - One bit per cycle; done pulses on the 8th cycle.

Test Plan:
- ADD A=0xF0, B=0x20, dest=3 -> next cycle wb_en=1, wb_addr=3, wb_data=0x10, carry=1, zero=0.
- SUB A=0x05, B=0x05, then JZ addr=0x9 -> zero=1, carry=0; jump_en=1 with jump_target=5'h09 one cycle after the JZ accept.
- CMP A=0x02, B=0x07 -> wb_en stays 0, carry=1, zero=0; a following JZ produces no jump_en.
- MUL A=0x12, B=0x10 -> in_ready=0 and busy=1 for 8 cycles, then wb_data=0x20 with carry=1 (product 0x120); a second in_valid during busy is ignored.
- Reset asserted 3 cycles into MUL -> all outputs 0 immediately, no wb_en after release, in_ready=1.
- HALT followed by ADD with in_valid held -> halted=1, in_ready=0, no wb_en until reset.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared types and widths for the 8-bit processor datapath.
// No logic; opcode encodings and execute-stage FSM states.
// Not applicable (package).
package proc_pkg;

    localparam int DATA_W = 8;
    localparam int REG_AW = 3;
    localparam int PC_W   = 5;
    localparam int ADDR_W = 4;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_XOR  = 4'h5,
        OP_NOT  = 4'h6,
        OP_SHL  = 4'h7,
        OP_SHR  = 4'h8,
        OP_MOV  = 4'h9,
        OP_INC  = 4'hA,
        OP_CMP  = 4'hB,
        OP_MUL  = 4'hC,
        OP_JMP  = 4'hD,
        OP_JZ   = 4'hE,
        OP_HALT = 4'hF
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MUL    = 2'd1,
        HALTED = 2'd2
    } exec_state_t;

endpackage

// File: rtl/seq_multiplier.sv
// Shift-add unsigned multiplier, one multiplier bit per cycle.
// Latency: done pulses in the DATA_W-th cycle after start; product valid with done.
// No backpressure: a start while running restarts the operation.
module seq_multiplier
    import proc_pkg::*;
#(
    parameter int DATA_W = proc_pkg::DATA_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic                  done,
    output logic [2*DATA_W-1:0]   product
);

    localparam int CNT_W = $clog2(DATA_W);

    logic                  run;
    logic [CNT_W-1:0]      cnt;
    logic [2*DATA_W-1:0]   acc;
    logic [2*DATA_W-1:0]   mcand;
    logic [2*DATA_W-1:0]   acc_nxt;
    logic [DATA_W-1:0]     mplier;

    assign acc_nxt = acc + (mplier[0] ? mcand : '0);
    // The last partial product is folded in combinationally so done and product coincide.
    assign done    = run && (cnt == CNT_W'(DATA_W - 1));
    assign product = acc_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run    <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (start) begin
            run    <= 1'b1;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= {{DATA_W{1'b0}}, a};
            mplier <= b;
        end else if (run) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
            if (done) begin
                run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/execute_unit.sv
// Execute/write-back stage: ALU, flags, register write port, jump requests, sequential MUL.
// Latency: 1 cycle for single-cycle ops, DATA_W+1 cycles to write-back for MUL.
// in_ready low during MUL and after HALT; in_valid while not ready is dropped, upstream holds.
module execute_unit #(
    parameter int DATA_W = proc_pkg::DATA_W,
    parameter int REG_AW = proc_pkg::REG_AW,
    parameter int PC_W   = proc_pkg::PC_W,
    parameter int ADDR_W = proc_pkg::ADDR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         opcode,
    input  logic [ADDR_W-1:0]  addr,
    input  logic [REG_AW-1:0]  dest,
    input  logic [DATA_W-1:0]  operand_a,
    input  logic [DATA_W-1:0]  operand_b,
    output logic               wb_en,
    output logic [REG_AW-1:0]  wb_addr,
    output logic [DATA_W-1:0]  wb_data,
    output logic               zero_flag,
    output logic               carry_flag,
    output logic               jump_en,
    output logic [PC_W-1:0]    jump_target,
    output logic               busy,
    output logic               halted
);

    import proc_pkg::*;

    exec_state_t           state;
    exec_state_t           state_nxt;
    opcode_t               op;
    logic                  accept;
    logic [DATA_W:0]       a_x;
    logic [DATA_W:0]       b_x;
    logic [DATA_W:0]       alu;
    logic                  alu_wr;
    logic                  alu_flags;
    logic                  mul_start;
    logic                  mul_done;
    logic [2*DATA_W-1:0]   mul_product;
    logic [REG_AW-1:0]     mul_dest;

    assign op       = opcode_t'(opcode);
    // Gated by reset so every output reads 0 while reset is held.
    assign in_ready = reset && (state == IDLE);
    assign accept   = in_valid && in_ready;
    assign busy     = (state == MUL);
    assign halted   = (state == HALTED);
    assign a_x      = {1'b0, operand_a};
    assign b_x      = {1'b0, operand_b};
    assign mul_start = accept && (op == OP_MUL);

    seq_multiplier #(
        .DATA_W (DATA_W)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (operand_a),
        .b       (operand_b),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept && op == OP_MUL) begin
                    state_nxt = MUL;
                end else if (accept && op == OP_HALT) begin
                    state_nxt = HALTED;
                end
            end
            MUL: begin
                if (mul_done) begin
                    state_nxt = IDLE;
                end
            end
            HALTED:  state_nxt = HALTED;
            default: state_nxt = IDLE;
        endcase
    end

    // Bit DATA_W of alu is the carry (or borrow for subtraction).
    always_comb begin
        alu       = '0;
        alu_wr    = 1'b0;
        alu_flags = 1'b0;
        case (op)
            OP_ADD: begin alu = a_x + b_x;                 alu_wr = 1'b1; end
            OP_SUB: begin alu = a_x - b_x;                 alu_wr = 1'b1; end
            OP_AND: begin alu = {1'b0, operand_a & operand_b}; alu_wr = 1'b1; end
            OP_OR:  begin alu = {1'b0, operand_a | operand_b}; alu_wr = 1'b1; end
            OP_XOR: begin alu = {1'b0, operand_a ^ operand_b}; alu_wr = 1'b1; end
            OP_NOT: begin alu = {1'b0, ~operand_a};        alu_wr = 1'b1; end
            OP_SHL: begin alu = {operand_a, 1'b0};         alu_wr = 1'b1; end
            OP_SHR: begin alu = {operand_a[0], 1'b0, operand_a[DATA_W-1:1]}; alu_wr = 1'b1; end
            OP_MOV: begin alu = a_x;                       alu_wr = 1'b1; end
            OP_INC: begin alu = a_x + {{DATA_W{1'b0}}, 1'b1}; alu_wr = 1'b1; end
            OP_CMP: begin alu = a_x - b_x;                 alu_flags = 1'b1; end
            default: begin alu = '0; end
        endcase
        alu_flags = alu_flags | alu_wr;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_en       <= 1'b0;
            wb_addr     <= '0;
            wb_data     <= '0;
            zero_flag   <= 1'b0;
            carry_flag  <= 1'b0;
            jump_en     <= 1'b0;
            jump_target <= '0;
            mul_dest    <= '0;
        end else begin
            wb_en   <= 1'b0;
            jump_en <= 1'b0;
            if (accept) begin
                if (alu_wr) begin
                    wb_en   <= 1'b1;
                    wb_addr <= dest;
                    wb_data <= alu[DATA_W-1:0];
                end
                if (alu_flags) begin
                    zero_flag  <= (alu[DATA_W-1:0] == '0);
                    carry_flag <= alu[DATA_W];
                end
                // JZ sees the flag as it stood before this edge.
                if (op == OP_JMP || (op == OP_JZ && zero_flag)) begin
                    jump_en     <= 1'b1;
                    jump_target <= {{(PC_W-ADDR_W){1'b0}}, addr};
                end
                if (op == OP_MUL) begin
                    mul_dest <= dest;
                end
            end else if (state == MUL && mul_done) begin
                wb_en      <= 1'b1;
                wb_addr    <= mul_dest;
                wb_data    <= mul_product[DATA_W-1:0];
                zero_flag  <= (mul_product[DATA_W-1:0] == '0);
                carry_flag <= (mul_product[2*DATA_W-1:DATA_W] != '0);
            end
        end
    end

endmodule

// File: tb/tb_execute_unit.sv
// Bench for execute_unit: directed scenarios plus random back-to-back ops against an arithmetic model.
module tb_execute_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] opcode;
    logic [3:0] addr;
    logic [2:0] dest;
    logic [7:0] operand_a;
    logic [7:0] operand_b;
    logic       wb_en;
    logic [2:0] wb_addr;
    logic [7:0] wb_data;
    logic       zero_flag;
    logic       carry_flag;
    logic       jump_en;
    logic [4:0] jump_target;
    logic       busy;
    logic       halted;

    int vectors = 0;
    int miscompares = 0;
    bit m_zero = 1'b0;
    bit m_carry = 1'b0;

    execute_unit dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .opcode      (opcode),
        .addr        (addr),
        .dest        (dest),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .zero_flag   (zero_flag),
        .carry_flag  (carry_flag),
        .jump_en     (jump_en),
        .jump_target (jump_target),
        .busy        (busy),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    task automatic drive(input bit v, input int op, input int a, input int b, input int d, input int ad);
        in_valid  = v;
        opcode    = 4'(op);
        operand_a = 8'(a);
        operand_b = 8'(b);
        dest      = 3'(d);
        addr      = 4'(ad);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference behaviour of one accepted single-cycle instruction, from the ISA rules.
    task automatic model_op(input int op, input int a, input int b,
                            output bit e_wb, output int e_data, output bit e_jmp);
        int r;
        bit fl;
        r = 0; fl = 1'b1; e_wb = 1'b1; e_jmp = 1'b0;
        case (op)
            1:  begin r = a + b;            m_carry = (r > 255); end
            2:  begin r = a - b + 256;      m_carry = (a < b); end
            3:  begin r = a & b;            m_carry = 1'b0; end
            4:  begin r = a | b;            m_carry = 1'b0; end
            5:  begin r = a ^ b;            m_carry = 1'b0; end
            6:  begin r = 255 - a;          m_carry = 1'b0; end
            7:  begin r = a * 2;            m_carry = (a >= 128); end
            8:  begin r = a / 2;            m_carry = (a % 2 == 1); end
            9:  begin r = a;                m_carry = 1'b0; end
            10: begin r = a + 1;            m_carry = (a == 255); end
            11: begin r = a - b + 256;      m_carry = (a < b); e_wb = 1'b0; end
            13: begin fl = 1'b0; e_wb = 1'b0; e_jmp = 1'b1; end
            14: begin fl = 1'b0; e_wb = 1'b0; e_jmp = m_zero; end
            default: begin fl = 1'b0; e_wb = 1'b0; end
        endcase
        e_data = r % 256;
        if (fl) m_zero = (e_data == 0);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #12;
        vectors++;
        if ({wb_en, wb_addr, wb_data, zero_flag, carry_flag, jump_en, jump_target, busy, halted, in_ready} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: wb_en=%b wb_data=%h z=%b c=%b jmp=%b busy=%b halted=%b in_ready=%b, all expected 0",
                     wb_en, wb_data, zero_flag, carry_flag, jump_en, busy, halted, in_ready);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_ready: in_ready=%b expected 1", in_ready);
        end
        m_zero = 1'b0; m_carry = 1'b0;
    endtask

    task automatic test_add();
        drive(1, 1, 8'hF0, 8'h20, 3, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        vectors++;
        if ({wb_en, wb_addr, wb_data, carry_flag, zero_flag} !== {1'b1, 3'd3, 8'h10, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL add_f0_20: wb_en=%b addr=%0d data=%h c=%b z=%b expected 1/3/10/1/0",
                     wb_en, wb_addr, wb_data, carry_flag, zero_flag);
        end
        tick();
        vectors++;
        if (wb_en !== 1'b0) begin
            miscompares++;
            $display("FAIL add_single_pulse: wb_en=%b expected 0", wb_en);
        end
        m_zero = 1'b0; m_carry = 1'b1;
    endtask

    task automatic test_sub_jz();
        drive(1, 2, 5, 5, 1, 0);
        tick();
        vectors++;
        if ({wb_en, wb_data, zero_flag, carry_flag} !== {1'b1, 8'h00, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL sub_equal: wb_en=%b data=%h z=%b c=%b expected 1/00/1/0",
                     wb_en, wb_data, zero_flag, carry_flag);
        end
        drive(1, 14, 0, 0, 0, 9);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        vectors++;
        if ({jump_en, jump_target, wb_en} !== {1'b1, 5'h09, 1'b0}) begin
            miscompares++;
            $display("FAIL jz_taken: jump_en=%b target=%h wb_en=%b expected 1/09/0", jump_en, jump_target, wb_en);
        end
        tick();
        vectors++;
        if (jump_en !== 1'b0) begin
            miscompares++;
            $display("FAIL jz_single_pulse: jump_en=%b expected 0", jump_en);
        end
        m_zero = 1'b1; m_carry = 1'b0;
    endtask

    task automatic test_cmp_jz();
        drive(1, 11, 2, 7, 4, 0);
        tick();
        vectors++;
        if ({wb_en, carry_flag, zero_flag} !== {1'b0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL cmp_flags: wb_en=%b c=%b z=%b expected 0/1/0", wb_en, carry_flag, zero_flag);
        end
        drive(1, 14, 0, 0, 0, 3);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        vectors++;
        if (jump_en !== 1'b0) begin
            miscompares++;
            $display("FAIL jz_not_taken: jump_en=%b expected 0", jump_en);
        end
        m_zero = 1'b0; m_carry = 1'b1;
    endtask

    // One MUL, with an ADD held on in_valid while busy to show it is dropped.
    task automatic run_mul(input int a, input int b, input int d, input bit poke);
        int p;
        p = a * b;
        drive(1, 12, a, b, d, 0);
        tick();
        drive(poke, 1, 8'h01, 8'h01, 7, 0);
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if ({in_ready, busy, wb_en} !== {1'b0, 1'b1, 1'b0}) begin
                miscompares++;
                $display("FAIL mul_busy_cycle%0d: in_ready=%b busy=%b wb_en=%b expected 0/1/0",
                         i, in_ready, busy, wb_en);
            end
            if (i == 7) drive(0, 0, 0, 0, 0, 0);
            tick();
        end
        m_zero = (p % 256 == 0);
        m_carry = (p > 255);
        vectors++;
        if ({wb_en, wb_addr, wb_data, carry_flag, zero_flag, in_ready, busy} !==
            {1'b1, 3'(d), 8'(p % 256), m_carry, m_zero, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL mul_%h_x_%h: wb_en=%b addr=%0d data=%h c=%b z=%b rdy=%b busy=%b expected data=%h c=%b z=%b",
                     a, b, wb_en, wb_addr, wb_data, carry_flag, zero_flag, in_ready, busy, p % 256, m_carry, m_zero);
        end
        tick();
        vectors++;
        if (wb_en !== 1'b0) begin
            miscompares++;
            $display("FAIL mul_ignored_input: wb_en=%b expected 0", wb_en);
        end
    endtask

    task automatic test_mul();
        run_mul(8'h12, 8'h10, 5, 1'b1);
        for (int k = 0; k < 4; k++) begin
            run_mul(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 7)), k[0]);
        end
        run_mul(0, 8'hAB, 2, 1'b0);
    endtask

    task automatic test_back_to_back();
        bit e_wb, e_jmp;
        int e_data, op, a, b, d, ad, r;
        bit v;
        for (int n = 0; n < 120; n++) begin
            r = int'($urandom_range(0, 13));
            op = (r < 12) ? r : r + 1;
            a = int'($urandom_range(0, 255));
            b = (n % 5 == 0) ? a : int'($urandom_range(0, 255));
            d = int'($urandom_range(0, 7));
            ad = int'($urandom_range(0, 15));
            v = ($urandom_range(0, 7) != 0);
            drive(v, op, a, b, d, ad);
            if (v) model_op(op, a, b, e_wb, e_data, e_jmp);
            else begin e_wb = 1'b0; e_jmp = 1'b0; e_data = 0; end
            tick();
            vectors++;
            if (wb_en !== e_wb || (e_wb && (wb_addr !== 3'(d) || wb_data !== 8'(e_data)))) begin
                miscompares++;
                $display("FAIL b2b_wb op=%0d a=%h b=%h: wb_en=%b addr=%0d data=%h expected %b/%0d/%h",
                         op, a, b, wb_en, wb_addr, wb_data, e_wb, d, e_data);
            end
            vectors++;
            if (zero_flag !== m_zero || carry_flag !== m_carry) begin
                miscompares++;
                $display("FAIL b2b_flags op=%0d a=%h b=%h: z=%b c=%b expected z=%b c=%b",
                         op, a, b, zero_flag, carry_flag, m_zero, m_carry);
            end
            vectors++;
            if (jump_en !== e_jmp || (e_jmp && jump_target !== 5'(ad))) begin
                miscompares++;
                $display("FAIL b2b_jump op=%0d: jump_en=%b target=%h expected %b/%h",
                         op, jump_en, jump_target, e_jmp, ad);
            end
        end
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_mul_reset();
        drive(1, 12, 8'hFF, 8'hFF, 6, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        #2;
        reset = 1'b0;
        #1;
        vectors++;
        if ({wb_en, wb_data, zero_flag, carry_flag, jump_en, busy, halted, in_ready} !== '0) begin
            miscompares++;
            $display("FAIL mul_reset_outputs: wb_en=%b data=%h z=%b c=%b busy=%b halted=%b rdy=%b expected all 0",
                     wb_en, wb_data, zero_flag, carry_flag, busy, halted, in_ready);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        m_zero = 1'b0; m_carry = 1'b0;
        for (int i = 0; i < 12; i++) begin
            vectors++;
            if ({wb_en, busy, in_ready} !== {1'b0, 1'b0, 1'b1}) begin
                miscompares++;
                $display("FAIL mul_reset_aborted%0d: wb_en=%b busy=%b in_ready=%b expected 0/0/1",
                         i, wb_en, busy, in_ready);
            end
            tick();
        end
    endtask

    task automatic test_halt();
        drive(1, 15, 0, 0, 0, 0);
        tick();
        drive(1, 1, 8'h11, 8'h22, 2, 0);
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if ({halted, in_ready, wb_en, busy} !== {1'b1, 1'b0, 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL halt_hold%0d: halted=%b in_ready=%b wb_en=%b busy=%b expected 1/0/0/0",
                         i, halted, in_ready, wb_en, busy);
            end
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        #1;
        vectors++;
        if (halted !== 1'b0) begin
            miscompares++;
            $display("FAIL halt_cleared_by_reset: halted=%b expected 0", halted);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_jz();
        test_cmp_jz();
        test_mul();
        test_back_to_back();
        test_mul_reset();
        test_back_to_back();
        test_halt();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
